uart_tx: RTL
============

Name: uart_tx

Overview:
Serial transmitter for the 8-bit UART link. It sends a start bit, then 8 data bits LSB first, then one stop bit, with no parity. It runs on the same 8x-baud clock domain as the link's receiver, so each bit is held for exactly CLKS_PER_BIT clocks. A single-entry holding register accepts the next byte while a frame is in flight, so frames can be sent back-to-back with no idle gap.

Parameters:
CLKS_PER_BIT, 8, clocks per serial bit (oversampling ratio; must be ≥2)
IDLE_LEVEL, 1'b1, line level when idle and during the stop bit

Ports:
clk  input  1  8x baud clock
reset  input  1  asynchronous, active-high reset
tx_en  input  1  transmitter enable
tx_start  input  1  request to load tx_data_in; sampled on clk rising edge
tx_data_in  input  8  byte to send
tx_data_out  output  1  serial line
ready  output  1  holding register empty; a tx_start is accepted only when ready=1
busy  output  1  a frame is on the line (start through stop)
done  output  1  one-cycle pulse after the stop bit completes

Behaviour:
- Clock and reset: reset is asynchronous, active-high; the clock is clk.
- Reset values: tx_data_out=IDLE_LEVEL, ready=1, busy=0, done=0, state=IDLE, holding register cleared/invalid, counters=0.
- Acceptance:
  - On an edge where tx_en && tx_start && ready, tx_data_in is captured into the hold register, hold_valid=1 and ready=0.
  - tx_start with ready=0 or tx_en=0 is ignored; no state change.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: line=IDLE_LEVEL, busy=0. If hold_valid && tx_en: load the shift register from hold, clear hold_valid (ready=1 next cycle), drive line=0, go to START, sample_cnt=0, bit_cnt=0.
  - Latency: accept at edge E0 → start bit on the line from E1.
  - START: line=0 for CLKS_PER_BIT clocks, then DATA.
  - DATA: line=shift_reg[bit_cnt] for CLKS_PER_BIT clocks per bit, LSB first. bit_cnt increments 0→7; after bit 7, go to STOP.
  - STOP: line=IDLE_LEVEL for CLKS_PER_BIT clocks. On the final STOP cycle edge, done is set for exactly one cycle.
    - If hold_valid && tx_en at that edge: reload and go directly to START (line=0 the next cycle, zero idle gap); busy stays 1.
    - Otherwise go to IDLE; busy=0.
- Frame timing: exactly 10*CLKS_PER_BIT clocks. busy=1 from the first start-bit cycle through the last stop-bit cycle.
- Counter widths: sample_cnt is $clog2(CLKS_PER_BIT) bits and wraps at CLKS_PER_BIT-1. bit_cnt is 3 bits.
- Same-edge load conflict: on an edge where the FSM takes the hold register, ready is still 0, so a simultaneous tx_start is rejected. ready returns to 1 one cycle later.
- Hold register stability: the shift register is separate from hold, so loading a new byte never disturbs the frame in flight.
- tx_en deasserted mid-frame: the current frame completes normally. A held byte stays held and starts only once tx_en=1 (from IDLE).
- Reset mid-frame: the line goes to IDLE_LEVEL immediately (asynchronous), the held byte is discarded, and there is no done pulse.
- The line output is registered; it has no combinational path from any input.

Test Plan:
- Reset: assert reset mid-idle → tx_data_out=1, ready=1, busy=0, done=0.
- Single frame 0xA5 (CLKS_PER_BIT=8), accept at E0:
  - line=0 during E1–E8; bits 1,0,1,0,0,1,0,1 for 8 clocks each during E9–E72; line=1 during E73–E80.
  - done=1 only for the cycle after E81; busy=1 for E1–E80.
- Back-to-back: send 0x55, then load 0x0F during its DATA phase → the second start bit begins at E81 with no idle cycle; two done pulses 80 clocks apart; busy never drops between frames.
- Full hold: while hold_valid=1, pulse tx_start with 0x33 → ignored; only the first two bytes appear on the line.
- Enable gating: load a byte, then deassert tx_en mid-frame → the current frame completes; the held byte waits in IDLE with the line at 1. When tx_en reasserts, the start bit appears one clock later.
- Reset during DATA bit 3 → the line goes to 1 within the same cycle, no done pulse, ready=1. Loopback into the link receiver with 0xC3 afterwards yields rx_data_out=0xC3.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter with a single-entry holding register for back-to-back frames.
module uart_tx #(
  parameter int   CLKS_PER_BIT = 8,
  parameter logic IDLE_LEVEL   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_en,
  input  logic       tx_start,
  input  logic [7:0] tx_data_in,
  output logic       tx_data_out,
  output logic       ready,
  output logic       busy,
  output logic       done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CMAX = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    hold_q, shift_q;
  logic          hold_valid_q, line_q, busy_q, done_q;
  logic          last, load;
  assign last = cnt_q == CMAX;
  // The FSM takes the held byte from IDLE or straight out of the final stop cycle.
  assign load = hold_valid_q && tx_en && (state_q == IDLE || (state_q == STOP && last));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      hold_q       <= '0;
      shift_q      <= '0;
      hold_valid_q <= 1'b0;
      line_q       <= IDLE_LEVEL;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      cnt_q  <= (state_q == IDLE || last) ? '0 : cnt_q + 1'b1;
      if (tx_en && tx_start && !hold_valid_q) begin
        hold_q       <= tx_data_in;
        hold_valid_q <= 1'b1;
      end
      case (state_q)
        IDLE: ;
        START: if (last) begin
          state_q <= DATA;
          line_q  <= shift_q[0];
        end
        DATA: if (last) begin
          bit_q   <= bit_q + 3'd1;
          state_q <= (bit_q == 3'd7) ? STOP : DATA;
          line_q  <= (bit_q == 3'd7) ? IDLE_LEVEL : shift_q[bit_q + 3'd1];
        end
        STOP: if (last) begin
          done_q <= 1'b1;
          if (!load) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
      endcase
      if (load) begin
        shift_q      <= hold_q;
        hold_valid_q <= 1'b0;
        state_q      <= START;
        bit_q        <= '0;
        line_q       <= 1'b0;
        busy_q       <= 1'b1;
      end
    end
  end
  assign tx_data_out = line_q;
  assign ready       = ~hold_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
endmodule
